// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic matrix-multiply top and its result drain:
// drain state encoding, accumulator width derivation and flat-vector element select.
`ifndef SYSTOLIC_RESULT_DRAIN_PKG_SV
`define SYSTOLIC_RESULT_DRAIN_PKG_SV

// Element (row,col) of an N x N matrix packed row-major into a flat vector of width-w fields.
`define DRAIN_ELEM(vec, row, col, n, w) vec[((row) * (n) + (col)) * (w) +: (w)]

package systolic_result_drain_pkg;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_STREAM = 1'b1
  } drain_state_e;

  // Accumulator width: full product plus headroom for N additions.
  function automatic int unsigned drain_acc_w(input int unsigned bit_w, input int unsigned n);
    return 2 * bit_w + unsigned'($clog2(n));
  endfunction

  // Row/column index width, at least one bit.
  function automatic int unsigned drain_idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

`endif

// File: rtl/systolic_result_drain_sat.sv
// Combinational ACC_W -> OUT_W result reducer: truncation by default,
// saturation to 2^OUT_W-1 when DRAIN_SAT_EN is defined.
module drain_sat #(
  parameter int unsigned ACC_W = 10,
  parameter int unsigned OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] data_c
);

`ifdef DRAIN_SAT_EN
  localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'({OUT_W{1'b1}});

  assign data_c = (acc_i > MAX_VAL) ? {OUT_W{1'b1}} : acc_i[OUT_W-1:0];
`else
  assign data_c = acc_i[OUT_W-1:0];

  // Upper accumulator bits are deliberately discarded by truncation.
  if (ACC_W > OUT_W) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^acc_i[ACC_W-1:OUT_W];
  end
`endif

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the N x N PE accumulators on done and streams them row-major over valid/ready.
// Optional saturation of each element is enabled with `define DRAIN_SAT_EN.
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned BIT_W = 4,
  parameter int unsigned ACC_W = drain_acc_w(BIT_W, N),
  parameter int unsigned OUT_W = 8,
  localparam int unsigned RC_W = drain_idx_w(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   done,
  input  logic [N*N*ACC_W-1:0]   acc_flat,
  output logic [OUT_W-1:0]       out_data,
  output logic [RC_W-1:0]        out_row,
  output logic [RC_W-1:0]        out_col,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   drain_done,
  output logic                   overrun
);

  localparam logic [RC_W-1:0] LAST_IDX = RC_W'(N - 1);

  drain_state_e           state_q, state_d;
  logic [RC_W-1:0]        row_q, row_d, col_q, col_d;
  logic [N*N*ACC_W-1:0]   buf_q, buf_d;
  logic [OUT_W-1:0]       data_q, data_d;
  logic                   last_q, last_d;
  logic                   dd_q, dd_d;
  logic                   ovr_q, ovr_d;
  logic                   capture, load, hs;
  logic [ACC_W-1:0]       elem;
  logic [OUT_W-1:0]       elem_red_c;

  assign hs = (state_q == DRAIN_STREAM) && out_ready;

  // Next state, index counters and status flags.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dd_d    = 1'b0;
    ovr_d   = ovr_q;
    capture = 1'b0;
    load    = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (done) begin
          capture = 1'b1;
          load    = 1'b1;
          state_d = DRAIN_STREAM;
          row_d   = '0;
          col_d   = '0;
        end
      end
      DRAIN_STREAM: begin
        if (hs && last_q) begin
          dd_d  = 1'b1;
          row_d = '0;
          col_d = '0;
          // A done coinciding with the final handshake restarts without a bubble.
          if (done) begin
            capture = 1'b1;
            load    = 1'b1;
          end else begin
            state_d = DRAIN_IDLE;
          end
        end else begin
          if (done) ovr_d = 1'b1;
          if (hs) begin
            load = 1'b1;
            if (col_q == LAST_IDX) begin
              col_d = '0;
              row_d = row_q + RC_W'(1);
            end else begin
              col_d = col_q + RC_W'(1);
            end
          end
        end
      end
      default: state_d = DRAIN_IDLE;
    endcase
  end

  // The element presented next comes straight from acc_flat on capture, else from the snapshot.
  assign buf_d  = capture ? acc_flat : buf_q;
  assign elem   = capture ? acc_flat[ACC_W-1:0] : `DRAIN_ELEM(buf_q, row_d, col_d, N, ACC_W);
  assign data_d = load ? elem_red_c : ((state_d == DRAIN_IDLE) ? '0 : data_q);
  assign last_d = (state_d == DRAIN_STREAM) && (row_d == LAST_IDX) && (col_d == LAST_IDX);

  drain_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc_i  (elem),
    .data_c (elem_red_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DRAIN_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      dd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      last_q  <= last_d;
      dd_q    <= dd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_valid  = (state_q == DRAIN_STREAM);
  assign busy       = (state_q == DRAIN_STREAM);
  assign out_data   = data_q;
  assign out_row    = row_q;
  assign out_col    = col_q;
  assign out_last   = last_q;
  assign drain_done = dd_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed table-driven bench for systolic_result_drain (N=3, ACC_W=10, OUT_W=8).
module tb_systolic_result_drain;

  localparam int unsigned N     = 3;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned ACC_W = 10;
  localparam int unsigned OUT_W = 8;
`ifdef DRAIN_SAT_EN
  localparam int EXP_OVF = 255;
`else
  localparam int EXP_OVF = 163;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 done;
  logic [N*N*ACC_W-1:0] acc_flat;
  logic [OUT_W-1:0]     out_data;
  logic [1:0]           out_row;
  logic [1:0]           out_col;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 drain_done;
  logic                 overrun;

  int total = 0;
  int bad   = 0;

  systolic_result_drain #(
    .N     (N),
    .BIT_W (BIT_W),
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .done       (done),
    .acc_flat   (acc_flat),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .drain_done (drain_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int done;
    int ready;
    int acc_sel;   // 0 keep, 1 values 1..9, 2 values 10..18, 3 all 675
    int valid;
    int data;
    int row;
    int col;
    int last;
    int dd;
    int ovr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [N*N*ACC_W-1:0] fill(input int sel);
    logic [N*N*ACC_W-1:0] f;
    int v;
    f = '0;
    for (int k = 0; k < 9; k++) begin
      v = (sel == 1) ? k + 1 : (sel == 2) ? k + 10 : 675;
      f[k*ACC_W +: ACC_W] = ACC_W'(v);
    end
    return f;
  endfunction

  // kind: 1 -> k+1, 2 -> k+10, 3 -> overflow value; k = row-major element index.
  task automatic add_el(input int d, input int r, input int sel, input int kind, input int k,
                        input int dd, input int ovr);
    vec_t v;
    v.done = d; v.ready = r; v.acc_sel = sel; v.valid = 1;
    v.data = (kind == 1) ? k + 1 : (kind == 2) ? k + 10 : EXP_OVF;
    v.row = k / 3; v.col = k % 3; v.last = (k == 8) ? 1 : 0; v.dd = dd; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input int d, input int r, input int dd, input int ovr);
    vec_t v;
    v.done = d; v.ready = r; v.acc_sel = 0; v.valid = 0;
    v.data = 0; v.row = 0; v.col = 0; v.last = 0; v.dd = dd; v.ovr = ovr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, -1, int'(out_valid), 0);
    chk({tag, "_busy"}, -1, int'(busy), 0);
    chk({tag, "_ddone"}, -1, int'(drain_done), 0);
    chk({tag, "_overrun"}, -1, int'(overrun), 0);
    chk({tag, "_data"}, -1, int'(out_data), 0);
    chk({tag, "_row"}, -1, int'(out_row), 0);
    chk({tag, "_col"}, -1, int'(out_col), 0);
    chk({tag, "_last"}, -1, int'(out_last), 0);
  endtask

  initial begin
    int cur;
    rst_n = 1'b0; done = 1'b0; out_ready = 1'b0; acc_flat = '0;

    // Identity run at full rate; acc_flat changed after capture must not matter.
    add_el(1, 1, 1, 1, 0, 0, 0);
    add_el(0, 1, 2, 1, 1, 0, 0);
    for (int k = 2; k < 9; k++) add_el(0, 1, 0, 1, k, 0, 0);
    add_idle(0, 1, 1, 0);
    add_idle(0, 1, 0, 0);

    // Backpressure: ready 1,0,0 repeating; 9 handshakes over 25 edges.
    add_el(1, 0, 1, 1, 0, 0, 0);
    cur = 0;
    for (int j = 0; j < 25; j++) begin
      if (j % 3 == 0) cur++;
      if (cur < 9) add_el(0, (j % 3 == 0) ? 1 : 0, 0, 1, cur, 0, 0);
      else         add_idle(0, 1, 1, 0);
    end
    add_idle(0, 1, 0, 0);

    // Back-to-back: second done on the final handshake, no bubble.
    add_el(1, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k < 9; k++) add_el(0, 1, 0, 1, k, 0, 0);
    add_el(1, 1, 2, 2, 0, 1, 0);
    for (int k = 1; k < 9; k++) add_el(0, 1, 0, 2, k, 0, 0);
    add_idle(0, 1, 1, 0);

    // Overflow width reduction.
    add_el(1, 1, 3, 3, 0, 0, 0);
    for (int k = 1; k < 9; k++) add_el(0, 1, 0, 3, k, 0, 0);
    add_idle(0, 1, 1, 0);

    // Overrun: done while element index 4 is stalled; stream continues unchanged.
    add_el(1, 1, 1, 1, 0, 0, 0);
    for (int k = 1; k < 5; k++) add_el(0, 1, 0, 1, k, 0, 0);
    add_el(1, 0, 2, 1, 4, 0, 1);
    for (int k = 5; k < 9; k++) add_el(0, 1, 0, 1, k, 0, 1);
    add_idle(0, 1, 1, 1);
    add_idle(0, 1, 0, 1);

    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      done      = vecs[i].done[0];
      out_ready = vecs[i].ready[0];
      if (vecs[i].acc_sel != 0) acc_flat = fill(vecs[i].acc_sel);
      @(posedge clk);
      #1;
      chk("valid", i, int'(out_valid), vecs[i].valid);
      chk("busy", i, int'(busy), vecs[i].valid);
      chk("drain_done", i, int'(drain_done), vecs[i].dd);
      chk("overrun", i, int'(overrun), vecs[i].ovr);
      if (vecs[i].valid != 0) begin
        chk("data", i, int'(out_data), vecs[i].data);
        chk("row", i, int'(out_row), vecs[i].row);
        chk("col", i, int'(out_col), vecs[i].col);
        chk("last", i, int'(out_last), vecs[i].last);
      end
    end

    // Reset mid-stream at element index 3.
    @(negedge clk);
    done = 1'b1; out_ready = 1'b1; acc_flat = fill(1);
    @(posedge clk); #1;
    @(negedge clk);
    done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_data", -1, int'(out_data), 4);
    chk("mid_row", -1, int'(out_row), 1);
    chk("mid_col", -1, int'(out_col), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    chk("rst_hold_ddone", -1, int'(drain_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", -1, int'(out_valid), 0);
    chk("post_rst_ddone", -1, int'(drain_done), 0);
    @(negedge clk);
    done = 1'b1; acc_flat = fill(2);
    @(posedge clk); #1;
    chk("restart_valid", -1, int'(out_valid), 1);
    chk("restart_data", -1, int'(out_data), 10);
    chk("restart_row", -1, int'(out_row), 0);
    chk("restart_col", -1, int'(out_col), 0);
    chk("restart_overrun", -1, int'(overrun), 0);
    @(negedge clk);
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the N x N systolic matrix-multiply top.
- When the controller signals that the array has finished, the block snapshots all N*N PE accumulators in one cycle.
- It then streams the snapshot out one element per handshake, in row-major order, over a valid/ready interface.
- Each element is reduced from accumulator width to output width by truncation, or by saturation when the optional feature is enabled.

Parameters:
- N, 3, matrix dimension; same value as the array.
- BIT_W, 4, operand width of matA/matB elements (unsigned).
- ACC_W, 2*BIT_W+$clog2(N), PE accumulator width (10 at defaults).
- OUT_W, 8, width of streamed result element; must be <= ACC_W.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- done  in  1  one-cycle pulse: array results final (controller entered READY).
- acc_flat  in  N*N*ACC_W  PE accumulators; element (r,c) at bits ((r*N+c)*ACC_W)+:ACC_W.
- out_data  out  OUT_W  current result element.
- out_row  out  $clog2(N) (min 1)  row index of out_data.
- out_col  out  $clog2(N) (min 1)  column index of out_data.
- out_valid  out  1  out_data/out_row/out_col/out_last are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_last  out  1  high with element (N-1,N-1).
- busy  out  1  high in STREAM.
- drain_done  out  1  one-cycle pulse after the last element is accepted.
- overrun  out  1  sticky: a done pulse was dropped.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, index=0, snapshot buffer=0. All outputs 0: out_valid, out_last, busy, drain_done, overrun, out_data, out_row, out_col. Reset mid-stream aborts the stream immediately; no partial drain_done.
- States: IDLE, STREAM.
- IDLE: on done=1, latch the full acc_flat into the snapshot buffer, set index=0, go to STREAM.
- Latency: done sampled at edge k gives out_valid=1 from the cycle after edge k, presenting (0,0).
- STREAM: out_valid=1 and busy=1. out_data/out_row/out_col reflect the buffer at the current index. Index runs 0..N*N-1, row=index/N, col=index%N; implement as separate row/col counters, col wrapping to 0 and incrementing row.
- Handshake: the index advances only on out_valid&&out_ready. With out_ready=0, all outputs are held stable (AXI-stream rule). The block never deasserts out_valid without a handshake.
- out_last=1 exactly when row=N-1 and col=N-1.
- Accepting the last element drives drain_done=1 for the next cycle and returns to IDLE (out_valid=0), unless the simultaneous-done rule below applies.
- Simultaneous done with the last handshake: capture the new snapshot, stay in STREAM at index 0. drain_done still pulses. No bubble cycle.
- done during STREAM at any other time: ignored, buffer unchanged, overrun set to 1. overrun clears only on reset.
- Width reduction, unsigned, without the feature: out_data = buffer element[OUT_W-1:0].
- acc_flat is only sampled on capture; changes afterwards have no effect on the stream.

Optional Feature:
- Macro: DRAIN_SAT_EN.
- Defined: out_data = (element > 2^OUT_W-1) ? 2^OUT_W-1 : element[OUT_W-1:0]. Saturation is combinational on the buffered element, so latency is unchanged.
- Undefined: plain truncation as above. No saturation logic is synthesized.

Decomposition:
- Shared package, alongside the systolic top's definitions:
  - state encodings DRAIN_IDLE=1'b0 and DRAIN_STREAM=1'b1;
  - ACC_W derivation helper;
  - flat-vector element-select macro for (row,col,width).
- One natural sub-module: drain_sat, the combinational ACC_W->OUT_W reducer containing the DRAIN_SAT_EN ifdef. Everything else stays in systolic_result_drain.

Test Plan:
- Identity × sequence, N=3: A=I, B=1..9 row-major (acc values 1..9), done pulse, out_ready=1. Expect out_data 1..9 on 9 consecutive cycles starting one cycle after done. (row,col) sequence is (0,0)..(2,2); out_last only on 9; drain_done on the cycle after.
- Overflow width: all A,B elements=15, so every acc=675. Without DRAIN_SAT_EN, expect every out_data=163 (675 mod 256). With it, expect every out_data=255.
- Backpressure: out_ready toggles 1,0,0,1,… during the identity run. Expect outputs held stable through each stall, all 9 elements delivered once in order, and total cycles = 9 + stall cycles.
- Overrun: done pulses again at element index 4. Expect the stream to continue 5..9 unchanged, overrun=1 and held until reset.
- Back-to-back: second done coincides with the last handshake, with new acc values 10..18. Expect drain_done pulse, no out_valid gap, next stream 10..18, overrun stays 0.
- Reset mid-stream: rst_n=0 at index 3. Expect all outputs 0 asynchronously and no drain_done. After release, a new done restarts from (0,0).
